// File: rtl/text_console_ctrl_pkg.sv
// text_console_ctrl_pkg: geometry, control codes, FSM states and cursor ops shared by the console sequencer.
package text_console_ctrl_pkg;
    localparam int COLS = 40;
    localparam int ROWS = 30;
    localparam int ADDR_W = 11;
    localparam logic [7:0] BLANK = 8'h20;
    localparam logic [7:0] CC_CR = 8'h0D;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [5:0] COL_MAX = 6'(COLS - 1);
    localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_ALL = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(COLS - 1);

    typedef enum logic [1:0] {CLR_ALL = 2'd0, IDLE = 2'd1, CLR_LINE = 2'd2} state_t;
    typedef enum logic [2:0] {OP_NONE, OP_INC, OP_NL, OP_CR, OP_BACK, OP_HOME} cur_op_t;

    function automatic logic is_printable(input logic [7:0] b);
        return b >= 8'h20 && b <= 8'h7E;
    endfunction
endpackage

// File: rtl/text_console_ctrl_cursor_ctr.sv
// text_console_ctrl_cursor_ctr: cursor col/row registers with registered row*COLS+col and row base address.
module text_console_ctrl_cursor_ctr
    import text_console_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  cur_op_t           op,
    output logic [5:0]        col,
    output logic [4:0]        row,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] base
);
    logic [5:0] col_n;
    logic [4:0] row_n, row_adv;
    logic [ADDR_W-1:0] base_n;
    logic wrap;

    // addr/base are registered from the next cursor so they always match col/row
    always_comb begin
        wrap = col == COL_MAX;
        row_adv = row == ROW_MAX ? '0 : row + 1'b1;
        col_n = op == OP_INC ? (wrap ? '0 : col + 1'b1) :
                (op == OP_CR || op == OP_HOME) ? '0 :
                (op == OP_BACK && col != '0) ? col - 1'b1 : col;
        row_n = (op == OP_NL || (op == OP_INC && wrap)) ? row_adv : op == OP_HOME ? '0 : row;
        base_n = ADDR_W'(row_n) * ADDR_W'(COLS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
            addr <= '0;
            base <= '0;
        end else begin
            col <= col_n;
            row <= row_n;
            base <= base_n;
            addr <= base_n + ADDR_W'(col_n);
        end
    end
endmodule

// File: rtl/text_console_ctrl.sv
// text_console_ctrl: turns a byte stream into tilemem character writes, handling CR/LF/BS/FF
// and running clear-screen / clear-line sweeps.
module text_console_ctrl
    import text_console_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [5:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy
);
    state_t state, state_n;
    cur_op_t op;
    logic [ADDR_W-1:0] cnt, cnt_n, addr, base, wa_n;
    logic [7:0] wd_n;
    logic we_n;

    text_console_ctrl_cursor_ctr u_cursor (
        .clk  (clk),
        .rst  (rst),
        .op   (op),
        .col  (cursor_col),
        .row  (cursor_row),
        .addr (addr),
        .base (base)
    );

    assign in_ready = state == IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLR_ALL;
            cnt <= '0;
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy <= 1'b1;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            wr_en <= we_n;
            wr_addr <= wa_n;
            wr_data <= wd_n;
            busy <= state_n != IDLE;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        op = OP_NONE;
        we_n = 1'b0;
        wa_n = wr_addr;
        wd_n = wr_data;
        case (state)
            CLR_ALL, CLR_LINE: begin
                we_n = 1'b1;
                wa_n = state == CLR_ALL ? cnt : base + cnt;
                wd_n = BLANK;
                cnt_n = cnt + 1'b1;
                if (cnt == (state == CLR_ALL ? LAST_ALL : LAST_LINE)) begin
                    cnt_n = '0;
                    state_n = IDLE;
                    op = state == CLR_ALL ? OP_HOME : OP_CR;
                end
            end
            IDLE: if (in_valid) begin
                if (is_printable(in_data)) begin
                    we_n = 1'b1;
                    wa_n = addr;
                    wd_n = in_data;
                    op = OP_INC;
                    if (cursor_col == COL_MAX) state_n = CLR_LINE;
                end else if (in_data == CC_CR) begin
                    op = OP_CR;
                end else if (in_data == CC_LF) begin
                    op = OP_NL;
                    state_n = CLR_LINE;
                end else if (in_data == CC_BS && cursor_col != '0) begin
                    we_n = 1'b1;
                    wa_n = addr - 1'b1;
                    wd_n = BLANK;
                    op = OP_BACK;
                end else if (in_data == CC_FF) begin
                    state_n = CLR_ALL;
                end
            end
            default: state_n = CLR_ALL;
        endcase
    end
endmodule

// File: tb/tb_text_console_ctrl.sv
// tb_text_console_ctrl: directed stimulus with a write scoreboard for text_console_ctrl.
module tb_text_console_ctrl;
    typedef struct packed {
        logic [10:0] a;
        logic [7:0]  d;
    } wr_t;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_ready, wr_en, busy;
    logic [10:0] wr_addr;
    logic [7:0] wr_data;
    logic [5:0] cursor_col;
    logic [4:0] cursor_row;
    int checks = 0, passed = 0;
    wr_t exp_q[$];
    wr_t mon_e;

    text_console_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int a, input logic [7:0] d);
        exp_q.push_back({11'(a), d});
    endtask

    task automatic push_blanks(input int a0, input int n);
        for (int i = 0; i < n; i++) push(a0 + i, 8'h20);
    endtask

    // drives one byte at the negedge; returns #1 after the accept edge
    task automatic accept(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data = b;
        chk("accept_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic sweep(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_wr_en"}, wr_en, 1);
            chk({tag, "_ready"}, in_ready, i == n - 1);
            chk({tag, "_busy"}, busy, i != n - 1);
        end
    endtask

    task automatic cursor(input string tag, input int c, input int r);
        chk({tag, "_col"}, cursor_col, c);
        chk({tag, "_row"}, cursor_row, r);
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            chk("sb_expected_write", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("sb_wr_addr", wr_addr, mon_e.a);
                chk("sb_wr_data", wr_data, mon_e.d);
            end
        end
    end

    initial begin
        // reset and initial clear-screen
        @(posedge clk);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 1);
        chk("rst_ready", in_ready, 0);
        cursor("rst", 0, 0);
        push_blanks(0, 1200);
        rst = 1'b0;
        sweep("init", 1200);
        cursor("init_done", 0, 0);
        @(posedge clk);
        #1 chk("idle_no_write", wr_en, 0);

        // two characters
        push(0, 8'h41);
        push(1, 8'h42);
        accept(8'h41);
        chk("A_wr_en", wr_en, 1);
        chk("A_addr", wr_addr, 0);
        accept(8'h42);
        chk("B_wr_en", wr_en, 1);
        chk("B_addr", wr_addr, 1);
        cursor("AB", 2, 0);

        // FF returns the cursor home
        push_blanks(0, 1200);
        accept(8'h0C);
        chk("ff_no_write", wr_en, 0);
        chk("ff_busy", busy, 1);
        sweep("ff", 1200);
        cursor("ff_done", 0, 0);

        // 41 printable bytes: line overflow clears row 1
        for (int i = 0; i < 40; i++) begin
            push(i, 8'h41 + 8'(i % 26));
            accept(8'h41 + 8'(i % 26));
            chk("line_wr_en", wr_en, 1);
        end
        cursor("overflow", 0, 1);
        push_blanks(40, 40);
        sweep("wrap_line", 40);
        push(40, 8'h7E);
        accept(8'h7E);
        chk("byte41_addr", wr_addr, 40);
        cursor("byte41", 1, 1);

        // walk down to row 29 with LFs
        for (int r = 2; r < 30; r++) begin
            push_blanks(r * 40, 40);
            accept(8'h0A);
            sweep("lf", 40);
        end
        cursor("row29", 0, 29);
        for (int i = 0; i < 5; i++) begin
            push(1160 + i, 8'h30 + 8'(i));
            accept(8'h30 + 8'(i));
        end
        cursor("col5_row29", 5, 29);

        // LF on the last row wraps to row 0 and blanks it
        push_blanks(0, 40);
        accept(8'h0A);
        chk("lf_no_write", wr_en, 0);
        cursor("lf_wrap", 5, 0);
        sweep("lf_wrap", 40);
        cursor("lf_wrap_done", 0, 0);
        accept(8'h0D);
        chk("cr_no_write", wr_en, 0);
        cursor("cr", 0, 0);
        accept(8'h08);
        chk("bs0_no_write", wr_en, 0);
        cursor("bs0", 0, 0);

        // move to 3/2, then backspace and an unknown code
        for (int r = 1; r < 3; r++) begin
            push_blanks(r * 40, 40);
            accept(8'h0A);
            sweep("lf2", 40);
        end
        for (int i = 0; i < 3; i++) begin
            push(80 + i, 8'h61 + 8'(i));
            accept(8'h61 + 8'(i));
        end
        cursor("pre_bs", 3, 2);
        push(82, 8'h20);
        accept(8'h08);
        chk("bs_wr_en", wr_en, 1);
        chk("bs_addr", wr_addr, 82);
        cursor("bs", 2, 2);
        accept(8'h07);
        chk("bel_no_write", wr_en, 0);
        chk("bel_ready", in_ready, 1);
        cursor("bel", 2, 2);

        // FF aborted by reset at write 500; held byte waits for the restarted sweep
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 8'h0C;
        push_blanks(0, 1200);
        @(posedge clk);
        #1 in_data = 8'h5A;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            chk("abort_wr_en", wr_en, 1);
            chk("abort_ready", in_ready, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        exp_q.delete();
        push_blanks(0, 1200);
        push(0, 8'h5A);
        @(posedge clk);
        #1;
        chk("abort_rst_wr_en", wr_en, 0);
        chk("abort_rst_ready", in_ready, 0);
        chk("abort_rst_busy", busy, 1);
        cursor("abort_rst", 0, 0);
        rst = 1'b0;
        sweep("restart", 1200);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("held_wr_en", wr_en, 1);
        chk("held_addr", wr_addr, 0);
        chk("held_data", wr_data, 8'h5A);
        cursor("held", 1, 0);
        repeat (3) @(posedge clk);
        #1 chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
